sdram_qos_arbiter: RTL and testbench

- Shares the single SDRAM controller command port (addr/data/we/req/rdy) among N requesters: TFT fetch, TFT write buffer, CPU/PPU cache.
- Arbitration order: urgent requesters first (e.g. TFT fetch near underrun), then aged requesters, then round-robin.
- Grant can be held for short bursts to the same requester.
- Drives the select used by the address/data/we muxes in front of the SDRAM controller.

---
 rtl/sdram_qos_arbiter_if.sv | 55 +++++
 rtl/sdram_qos_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdram_qos_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_qos_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_qos_arbiter_if
// Bundles the requester-side handshake and the SDRAM controller command-port
// handshake that sdram_qos_arbiter arbitrates.
//
// Signals (N = number of requesters):
//   req     [N]        per-requester request level
//   urgent  [N]        per-requester urgency, qualified by req
//   sel     [N]        one-hot grant, zero when nothing is granted
//   sel_idx [clog2(N)] binary index of the granted requester (holds when idle)
//   ifreq              command request towards the SDRAM controller
//   ifrdy              controller accepted the command this cycle
//   rdy     [N]        per-requester accept pulse
//   aged    [N]        debug: requester has waited at least AGE cycles
//
// Modports:
//   master : the arbiter, which drives the grant side
//   slave  : the requesters plus controller, which drive req/urgent/ifrdy
// ---------------------------------------------------------------------------
interface sdram_qos_arbiter_if #(
    parameter int N = 3
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  urgent;
    logic [N-1:0]  sel;
    logic [IW-1:0] sel_idx;
    logic          ifreq;
    logic          ifrdy;
    logic [N-1:0]  rdy;
    logic [N-1:0]  aged;

    modport master (
        input  req,
        input  urgent,
        input  ifrdy,
        output sel,
        output sel_idx,
        output ifreq,
        output rdy,
        output aged
    );

    modport slave (
        output req,
        output urgent,
        output ifrdy,
        input  sel,
        input  sel_idx,
        input  ifreq,
        input  rdy,
        input  aged
    );
endinterface

// File: rtl/sdram_qos_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_qos_arbiter
// Shares the single SDRAM controller command port among N requesters
// (TFT fetch, TFT write buffer, CPU/PPU cache). Urgent requesters win first,
// then requesters that have waited AGE cycles, then round-robin. A winner may
// keep the port for up to BURST consecutive accepts. Every accept is followed
// by one idle arbitration cycle so the requester can update its address/data.
//
// Parameters:
//   N     number of requesters (2..8)
//   BURST max consecutive accepts for one requester (1..15)
//   AGE   wait cycles before a pending requester is promoted to aged (1..255)
//
// Ports:
//   clk    controller clock
//   reset  synchronous active-high reset
//   bus    sdram_qos_arbiter_if.master: req/urgent/ifrdy in,
//          sel/sel_idx/ifreq/rdy/aged out
// ---------------------------------------------------------------------------
module sdram_qos_arbiter #(
    parameter int N     = 3,
    parameter int BURST = 4,
    parameter int AGE   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    sdram_qos_arbiter_if.master    bus
);
    localparam int           IW      = $clog2(N);
    localparam logic [3:0]   BURST_L = 4'(BURST);
    localparam logic [7:0]   AGE_L   = 8'(AGE);

    typedef enum logic {
        ARB,
        GRANT
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_sel;
    logic [IW-1:0]  r_selIdx;
    logic           r_ifreq;
    logic [IW-1:0]  r_last;
    logic [3:0]     r_burstCnt;

    logic [N-1:0]   w_rdy;
    logic [N-1:0]   w_aged;
    logic [N-1:0]   w_urgVec;
    logic [N-1:0]   w_agedVec;
    logic [N-1:0]   w_lastOnehot;
    logic           w_burstOk;
    logic [IW-1:0]  w_winner;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Descending scan so the lowest set index is the last one written.
    function automatic logic [IW-1:0] lowestIdx(input logic [N-1:0] v);
        logic [IW-1:0] pick;
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i[IW-1:0]]) pick = i[IW-1:0];
        end
        return pick;
    endfunction

    // Round-robin: first requester after 'last', wrapping modulo N.
    function automatic logic [IW-1:0] rrPick(input logic [N-1:0] reqV,
                                             input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        int            j;
        pick = last;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (reqV[j[IW-1:0]]) pick = j[IW-1:0];
        end
        return pick;
    endfunction

    // Accept pulses only exist while a grant is presented to the controller.
    assign w_rdy = (r_state == GRANT && bus.ifrdy) ? r_sel : '0;

    // Winner selection. A burst may continue only while no other pending
    // requester is urgent or aged, so aging bounds the wait even against
    // bursts. A zero burst count means the last winner never got an accept
    // (after reset or an idle cycle), so there is nothing to continue.
    always_comb begin
        w_lastOnehot = onehot(r_last);
        w_urgVec     = bus.req & bus.urgent;
        w_agedVec    = bus.req & w_aged;
        w_burstOk    = (r_burstCnt != 4'd0) && (r_burstCnt < BURST_L) &&
                       bus.req[r_last] &&
                       (((w_urgVec | w_agedVec) & ~w_lastOnehot) == '0);
        if (w_burstOk)
            w_winner = r_last;
        else if (|w_urgVec)
            w_winner = lowestIdx(w_urgVec);
        else if (|w_agedVec)
            w_winner = lowestIdx(w_agedVec);
        else
            w_winner = rrPick(bus.req, r_last);
    end

    // ARB/GRANT state machine with registered grant outputs. A fresh
    // (non-burst) win clears the burst count so the next accept sets it to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_sel      <= '0;
            r_selIdx   <= IW'(N - 1);
            r_ifreq    <= 1'b0;
            r_last     <= IW'(N - 1);
            r_burstCnt <= 4'd0;
        end else begin
            case (r_state)
                ARB: begin
                    if (bus.req == '0) begin
                        r_burstCnt <= 4'd0;
                    end else begin
                        r_state  <= GRANT;
                        r_sel    <= onehot(w_winner);
                        r_selIdx <= w_winner;
                        r_ifreq  <= 1'b1;
                        if (!w_burstOk) r_burstCnt <= 4'd0;
                    end
                end
                GRANT: begin
                    if (bus.ifrdy) begin
                        r_state    <= ARB;
                        r_sel      <= '0;
                        r_ifreq    <= 1'b0;
                        r_last     <= r_selIdx;
                        r_burstCnt <= r_burstCnt + 4'd1;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Per-requester wait counters. The aged flag is registered from the
    // counter value, so it appears one cycle after the counter saturates.
    for (genvar gi = 0; gi < N; gi++) begin : g_wait
        logic [7:0] r_wait;
        logic       r_agedBit;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wait    <= 8'd0;
                r_agedBit <= 1'b0;
            end else begin
                r_agedBit <= (r_wait >= AGE_L);
                if (!bus.req[gi] || w_rdy[gi])
                    r_wait <= 8'd0;
                else if (!r_sel[gi])
                    r_wait <= (r_wait >= AGE_L) ? AGE_L : r_wait + 8'd1;
            end
        end

        assign w_aged[gi] = r_agedBit;
    end

    assign bus.sel     = r_sel;
    assign bus.sel_idx = r_selIdx;
    assign bus.ifreq   = r_ifreq;
    assign bus.rdy     = w_rdy;
    assign bus.aged    = w_aged;

endmodule

// File: tb/tb_sdram_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_qos_arbiter
// Drives two arbiter instances with identical stimulus: A (BURST=4, AGE=64)
// and B (BURST=15, AGE=8). Each cycle both are compared against a reference
// model built from the arbitration rules; directed scenarios add fixed
// expected values for grant order, urgency pre-emption, aging, reset
// mid-grant and a long stall.
// ---------------------------------------------------------------------------
module tb_sdram_qos_arbiter;
    logic       clk;
    logic       tReset;
    logic [2:0] tReq;
    logic [2:0] tUrg;
    logic       tIfrdy;

    int nAsserts = 0;
    int nFails   = 0;

    sdram_qos_arbiter_if #(.N(3)) busA ();
    sdram_qos_arbiter_if #(.N(3)) busB ();

    assign busA.req    = tReq;
    assign busA.urgent = tUrg;
    assign busA.ifrdy  = tIfrdy;
    assign busB.req    = tReq;
    assign busB.urgent = tUrg;
    assign busB.ifrdy  = tIfrdy;

    sdram_qos_arbiter #(.N(3), .BURST(4), .AGE(64)) dutA (
        .clk   (clk),
        .reset (tReset),
        .bus   (busA)
    );

    sdram_qos_arbiter #(.N(3), .BURST(15), .AGE(8)) dutB (
        .clk   (clk),
        .reset (tReset),
        .bus   (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one set per instance.
    int burstP[2] = '{4, 15};
    int ageP[2]   = '{64, 8};
    bit mGrant[2];
    int mIdx[2];
    int mLast[2];
    int mBurst[2];
    int mWait[2][3];
    bit mAged[2][3];

    function automatic logic [2:0] expSel(input int d);
        return mGrant[d] ? (3'b001 << mIdx[d]) : 3'b000;
    endfunction

    function automatic logic [2:0] expRdy(input int d);
        return (mGrant[d] && tIfrdy) ? expSel(d) : 3'b000;
    endfunction

    function automatic logic [2:0] expAged(input int d);
        return {mAged[d][2], mAged[d][1], mAged[d][0]};
    endfunction

    // Winner: urgent, then aged, then round-robin after last; a running
    // burst keeps the last winner unless someone else is urgent or aged.
    function automatic int pickWinner(input int d, output bit cont);
        bit rq[3];
        bit ug[3];
        bit blocked;
        bit found;
        int w;
        for (int j = 0; j < 3; j++) begin
            rq[j] = tReq[j];
            ug[j] = tUrg[j];
        end
        blocked = 0;
        for (int j = 0; j < 3; j++)
            if (j != mLast[d] && rq[j] && (ug[j] || mAged[d][j])) blocked = 1;
        cont = (mBurst[d] > 0) && (mBurst[d] < burstP[d]) && rq[mLast[d]] && !blocked;
        found = 0;
        w = mLast[d];
        if (cont) found = 1;
        for (int j = 0; j < 3; j++)
            if (!found && rq[j] && ug[j]) begin w = j; found = 1; end
        for (int j = 0; j < 3; j++)
            if (!found && rq[j] && mAged[d][j]) begin w = j; found = 1; end
        for (int k = 1; k <= 3; k++)
            if (!found && rq[(mLast[d] + k) % 3]) begin w = (mLast[d] + k) % 3; found = 1; end
        return w;
    endfunction

    task automatic modelStep(input int d);
        logic [2:0] selNow;
        logic [2:0] rdyNow;
        bit         newAged[3];
        bit         cont;
        int         w;
        if (tReset) begin
            mGrant[d] = 0;
            mIdx[d]   = 2;
            mLast[d]  = 2;
            mBurst[d] = 0;
            for (int i = 0; i < 3; i++) begin
                mWait[d][i] = 0;
                mAged[d][i] = 0;
            end
        end else begin
            selNow = expSel(d);
            rdyNow = expRdy(d);
            for (int i = 0; i < 3; i++) begin
                newAged[i] = (mWait[d][i] >= ageP[d]);
                if (!tReq[i] || rdyNow[i])
                    mWait[d][i] = 0;
                else if (!selNow[i])
                    mWait[d][i] = (mWait[d][i] + 1 > ageP[d]) ? ageP[d] : mWait[d][i] + 1;
            end
            if (!mGrant[d]) begin
                if (tReq == 3'b000) begin
                    mBurst[d] = 0;
                end else begin
                    w = pickWinner(d, cont);
                    if (!cont) mBurst[d] = 0;
                    mGrant[d] = 1;
                    mIdx[d]   = w;
                end
            end else if (tIfrdy) begin
                mLast[d]  = mIdx[d];
                mBurst[d] = mBurst[d] + 1;
                mGrant[d] = 0;
            end
            for (int i = 0; i < 3; i++) mAged[d][i] = newAged[i];
        end
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] oSel, oRdy, oAged;
        logic [1:0] oIdx;
        logic       oIfreq;
        string      nm;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                oSel = busA.sel; oRdy = busA.rdy; oAged = busA.aged;
                oIdx = busA.sel_idx; oIfreq = busA.ifreq; nm = "A";
            end else begin
                oSel = busB.sel; oRdy = busB.rdy; oAged = busB.aged;
                oIdx = busB.sel_idx; oIfreq = busB.ifreq; nm = "B";
            end
            checkEq({nm, ".sel"},     32'(oSel),   32'(expSel(d)));
            checkEq({nm, ".sel_idx"}, 32'(oIdx),   32'(mIdx[d]));
            checkEq({nm, ".ifreq"},   32'(oIfreq), 32'(mGrant[d]));
            checkEq({nm, ".rdy"},     32'(oRdy),   32'(expRdy(d)));
            checkEq({nm, ".aged"},    32'(oAged),  32'(expAged(d)));
        end
    endtask

    // Drive one cycle's inputs and compare both DUTs to the model.
    task automatic applyStimulus(input logic rst, input logic [2:0] r,
                                 input logic [2:0] u, input logic rd);
        tReset = rst;
        tReq   = r;
        tUrg   = u;
        tIfrdy = rd;
        #1;
        checkOutput();
    endtask

    // Advance the model across the coming edge and move to the next negedge.
    task automatic tick();
        modelStep(0);
        modelStep(1);
        @(negedge clk);
    endtask

    task automatic cycle(input logic rst, input logic [2:0] r,
                         input logic [2:0] u, input logic rd);
        applyStimulus(rst, r, u, rd);
        tick();
    endtask

    int         exp2[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    logic [2:0] acceptLog[$];
    logic [2:0] rndReq;
    logic [2:0] rndUrg;

    initial begin
        tReset = 1'b1;
        tReq   = 3'b000;
        tUrg   = 3'b000;
        tIfrdy = 1'b0;
        @(negedge clk);
        $display("[TB] reset");
        tick();
        cycle(1, 3'b000, 3'b000, 0);
        applyStimulus(0, 3'b000, 3'b000, 0);
        checkEq("rst_sel",     32'(busA.sel),     32'h0);
        checkEq("rst_sel_idx", 32'(busA.sel_idx), 32'h2);
        checkEq("rst_ifreq",   32'(busA.ifreq),   32'h0);
        checkEq("rst_aged",    32'(busA.aged),    32'h0);
        tick();

        $display("[TB] single requester, ifrdy tied high");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 3'b001, 3'b000, 1);
            checkEq("t1_ifreq", 32'(busA.ifreq), 32'(k % 2));
            checkEq("t1_rdy",   32'(busA.rdy),   32'(k % 2));
            checkEq("t1_sel",   32'(busA.sel),   32'(k % 2));
            tick();
        end
        for (int k = 0; k < 3; k++) cycle(0, 3'b000, 3'b000, 1);

        $display("[TB] three requesters, burst rotation");
        cycle(1, 3'b000, 3'b000, 0);
        for (int k = 0; k < 26; k++) begin
            applyStimulus(0, 3'b111, 3'b000, 1);
            if (busA.rdy != 3'b000) acceptLog.push_back(busA.rdy);
            tick();
        end
        checkEq("t2_count", 32'(acceptLog.size()), 32'd13);
        for (int i = 0; i < 13; i++)
            checkEq($sformatf("t2_order%0d", i),
                    32'((i < acceptLog.size()) ? acceptLog[i] : 3'b000),
                    32'(3'b001 << exp2[i]));

        $display("[TB] urgency pre-empts a burst");
        cycle(1, 3'b000, 3'b000, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 3'b011, (k >= 4) ? 3'b010 : 3'b000, 1);
            if (k == 1 || k == 3) checkEq("t3_rdy0", 32'(busA.rdy), 32'h1);
            if (k == 5) begin
                checkEq("t3_rdy1", 32'(busA.rdy),     32'h2);
                checkEq("t3_idx1", 32'(busA.sel_idx), 32'h1);
            end
            tick();
        end

        $display("[TB] aging beats a long burst");
        cycle(1, 3'b000, 3'b000, 0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 3'b101, 3'b000, 1);
            if (k == 8)  checkEq("t4_aged_before", 32'(busB.aged), 32'h0);
            if (k == 9) begin
                checkEq("t4_aged_after", 32'(busB.aged), 32'h4);
                checkEq("t4_sel_burst",  32'(busB.sel),  32'h1);
            end
            if (k == 10) checkEq("t4_bubble", 32'(busB.ifreq), 32'h0);
            if (k == 11) begin
                checkEq("t4_sel2", 32'(busB.sel), 32'h4);
                checkEq("t4_rdy2", 32'(busB.rdy), 32'h4);
            end
            tick();
        end

        $display("[TB] reset mid-grant, then long stall");
        cycle(1, 3'b000, 3'b000, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 3'b111, 3'b000, 0);
            if (k == 2) checkEq("t5_granted", 32'(busA.ifreq), 32'h1);
            tick();
        end
        cycle(1, 3'b111, 3'b000, 0);
        applyStimulus(0, 3'b110, 3'b000, 0);
        checkEq("t5_rst_ifreq", 32'(busA.ifreq), 32'h0);
        checkEq("t5_rst_sel",   32'(busA.sel),   32'h0);
        checkEq("t5_rst_aged",  32'(busB.aged),  32'h0);
        tick();
        for (int k = 0; k < 100; k++) begin
            applyStimulus(0, 3'b110, 3'b000, 0);
            checkEq("t5_sel",   32'(busA.sel),   32'h2);
            checkEq("t5_ifreq", 32'(busA.ifreq), 32'h1);
            checkEq("t5_rdy",   32'(busA.rdy),   32'h0);
            tick();
        end
        applyStimulus(0, 3'b110, 3'b000, 0);
        checkEq("t5_agedA", 32'(busA.aged), 32'h4);
        checkEq("t5_agedB", 32'(busB.aged), 32'h4);
        tick();

        $display("[TB] randomized traffic");
        rndReq = 3'b000;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) rndReq[i] = ~rndReq[i];
                rndUrg[i] = ($urandom_range(0, 7) == 0);
            end
            cycle(($urandom_range(0, 199) == 0), rndReq, rndUrg,
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
